// File: rtl/onewire_scratchpad_rx.sv
// rtl/onewire_scratchpad_rx.sv - 1-Wire scratchpad frame assembler with bit-serial Dallas CRC-8 check
module onewire_scratchpad_rx #(
  parameter int unsigned FRAME_BYTES = 9,
  parameter logic [7:0]  CRC_POLY    = 8'h8C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        byte_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        crc_ok,
  output logic [15:0] temp_out,
  output logic [7:0]  th_out,
  output logic [7:0]  tl_out,
  output logic [7:0]  config_out
);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, DONE} state_t;

  localparam logic [3:0] FRAME_CNT = 4'(FRAME_BYTES);

  state_t          state_q, state_d;
  logic [7:0]      crc_q, crc_d;
  logic [7:0]      shift_q, shift_d;
  logic [3:0]      byte_cnt_q, byte_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [4:0][7:0] capt_q, capt_d;
  logic            crc_ok_q, crc_ok_d;
  logic [15:0]     temp_q, temp_d;
  logic [7:0]      th_q, th_d;
  logic [7:0]      tl_q, tl_d;
  logic [7:0]      cfg_q, cfg_d;
  logic            fb;
  logic [3:0]      byte_cnt_inc;

  assign byte_cnt_inc = byte_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    capt_d     = capt_q;
    crc_ok_d   = crc_ok_q;
    temp_d     = temp_q;
    th_d       = th_q;
    tl_d       = tl_q;
    cfg_d      = cfg_q;
    fb         = 1'b0;
    frame_done = 1'b0;
    byte_ready = (state_q == WAIT_BYTE);
    busy       = (state_q != IDLE);

    // A restart wins over everything, including a byte offered in the same cycle.
    if (frame_start) begin
      state_d    = WAIT_BYTE;
      crc_d      = 8'h00;
      byte_cnt_d = 4'd0;
      bit_cnt_d  = 3'd0;
    end else begin
      case (state_q)
        IDLE: ;
        WAIT_BYTE: begin
          if (byte_valid) begin
            shift_d   = byte_in;
            bit_cnt_d = 3'd0;
            state_d   = SHIFT;
            for (int i = 0; i < 5; i++) begin
              if (byte_cnt_q == 4'(i)) capt_d[i] = byte_in;
            end
          end
        end
        SHIFT: begin
          fb        = crc_q[0] ^ shift_q[0];
          crc_d     = {1'b0, crc_q[7:1]} ^ (fb ? CRC_POLY : 8'h00);
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = byte_cnt_inc;
            state_d    = (byte_cnt_inc == FRAME_CNT) ? DONE : WAIT_BYTE;
          end
        end
        DONE: begin
          frame_done = !rst;
          crc_ok_d   = (crc_q == 8'h00);
          if (crc_q == 8'h00) begin
            temp_d = {capt_q[1], capt_q[0]};
            th_d   = capt_q[2];
            tl_d   = capt_q[3];
            cfg_d  = capt_q[4];
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      crc_q      <= 8'h00;
      shift_q    <= 8'h00;
      byte_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      capt_q     <= '0;
      crc_ok_q   <= 1'b0;
      temp_q     <= 16'h0000;
      th_q       <= 8'h00;
      tl_q       <= 8'h00;
      cfg_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      capt_q     <= capt_d;
      crc_ok_q   <= crc_ok_d;
      temp_q     <= temp_d;
      th_q       <= th_d;
      tl_q       <= tl_d;
      cfg_q      <= cfg_d;
    end
  end

  assign crc_ok     = crc_ok_q;
  assign temp_out   = temp_q;
  assign th_out     = th_q;
  assign tl_out     = tl_q;
  assign config_out = cfg_q;

endmodule

// File: tb/tb_onewire_scratchpad_rx.sv
// tb/tb_onewire_scratchpad_rx.sv - self-checking bench for onewire_scratchpad_rx
module tb_onewire_scratchpad_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready;
  logic        busy;
  logic        frame_done;
  logic        crc_ok;
  logic [15:0] temp_out;
  logic [7:0]  th_out;
  logic [7:0]  tl_out;
  logic [7:0]  config_out;

  onewire_scratchpad_rx dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_ready (byte_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .crc_ok     (crc_ok),
    .temp_out   (temp_out),
    .th_out     (th_out),
    .tl_out     (tl_out),
    .config_out (config_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:8][7:0] b;
    logic            exp_ok;
    logic [15:0]     exp_temp;
    logic [7:0]      exp_th;
    logic [7:0]      exp_tl;
    logic [7:0]      exp_cfg;
  } vec_t;

  vec_t vecs [4];

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cnt  = 0;
  int acc_cyc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out (cycle %0d)", name, cyc);
  endtask

  // Drive one cycle's inputs just after the falling edge, then sample outputs.
  task automatic step(input logic fs, input logic bv, input logic [7:0] bi, input logic r);
    @(negedge clk);
    cyc++;
    rst         = r;
    frame_start = fs;
    byte_valid  = bv;
    byte_in     = bi;
    #1;
    if (bv && byte_ready && !fs && !r) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  a0;
    logic got;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      a0 = acc_cnt;
      step(1'b0, 1'b1, b, 1'b0);
      if (acc_cnt != a0) got = 1'b1;
    end
    if (!got) timeout("send_byte");
  endtask

  task automatic wait_done(input int budget);
    int   d0;
    logic got;
    d0  = done_cnt;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (done_cnt != d0) got = 1'b1;
    end
    if (!got) timeout("wait_done");
  endtask

  initial begin
    int   d0;
    int   a0;
    int   last_acc;
    int   n;
    logic prev_ok;
    logic got;

    vecs[0] = '{b: {8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C},
                exp_ok: 1'b1, exp_temp: 16'h0550, exp_th: 8'h4B, exp_tl: 8'h46, exp_cfg: 8'h7F};
    vecs[1] = '{b: {8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1D},
                exp_ok: 1'b0, exp_temp: 16'h0550, exp_th: 8'h4B, exp_tl: 8'h46, exp_cfg: 8'h7F};
    vecs[2] = '{b: {8'h51, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C},
                exp_ok: 1'b0, exp_temp: 16'h0550, exp_th: 8'h4B, exp_tl: 8'h46, exp_cfg: 8'h7F};
    vecs[3] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                exp_ok: 1'b1, exp_temp: 16'h0000, exp_th: 8'h00, exp_tl: 8'h00, exp_cfg: 8'h00};

    rst = 1'b1; frame_start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_crc_ok",     32'(crc_ok),     32'd0);
    check("rst_temp",       32'(temp_out),   32'd0);
    check("rst_th",         32'(th_out),     32'd0);
    check("rst_tl",         32'(tl_out),     32'd0);
    check("rst_config",     32'(config_out), 32'd0);

    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("idle_busy", 32'(busy), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("start_cycle_ready", 32'(byte_ready), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("start_plus1_ready", 32'(byte_ready), 32'd1);
    check("start_plus1_busy",  32'(busy),       32'd1);

    prev_ok = 1'b0;
    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt;
      step(1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 9; k++) send_byte(vecs[v].b[k]);
      last_acc = acc_cyc;
      wait_done(20);
      check("done_latency",   32'(done_cyc - last_acc), 32'd9);
      check("ok_hold_in_done", 32'(crc_ok), 32'(prev_ok));
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check("done_pulses", 32'(done_cnt - d0), 32'd1);
      check("post_busy",   32'(busy),          32'd0);
      check("vec_crc_ok",  32'(crc_ok),        32'(vecs[v].exp_ok));
      check("vec_temp",    32'(temp_out),      32'(vecs[v].exp_temp));
      check("vec_th",      32'(th_out),        32'(vecs[v].exp_th));
      check("vec_tl",      32'(tl_out),        32'(vecs[v].exp_tl));
      check("vec_config",  32'(config_out),    32'(vecs[v].exp_cfg));
      prev_ok = vecs[v].exp_ok;
    end

    // Backpressure: byte_valid held high for the whole frame.
    d0 = done_cnt;
    a0 = acc_cnt;
    n  = 0;
    last_acc = 0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 90; i++) begin
      int a1;
      a1 = acc_cnt;
      step(1'b0, 1'b1, 8'h00, 1'b0);
      if (acc_cnt != a1) begin
        if (n > 0) check("bp_spacing", 32'(acc_cyc - last_acc), 32'd9);
        last_acc = acc_cyc;
        n++;
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("bp_accepts", 32'(acc_cnt - a0),        32'd9);
    check("bp_dones",   32'(done_cnt - d0),       32'd1);
    check("bp_latency", 32'(done_cyc - last_acc), 32'd9);
    check("bp_crc_ok",  32'(crc_ok),              32'd1);

    // Abort after 4 bytes with a coincident byte_valid on the restart.
    d0 = done_cnt;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(vecs[0].b[k]);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (byte_ready) got = 1'b1;
    end
    if (!got) timeout("abort_ready");
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("abort_drop_byte", 32'(byte_ready), 32'd1);
    for (int k = 0; k < 9; k++) send_byte(vecs[0].b[k]);
    wait_done(20);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("abort_dones",  32'(done_cnt - d0), 32'd1);
    check("abort_crc_ok", 32'(crc_ok),        32'd1);
    check("abort_temp",   32'(temp_out),      32'h0550);

    // Reset mid-frame after 3 bytes.
    d0 = done_cnt;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(vecs[0].b[k]);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("midrst_busy",   32'(busy),       32'd0);
    check("midrst_ready",  32'(byte_ready), 32'd0);
    check("midrst_crc_ok", 32'(crc_ok),     32'd0);
    check("midrst_temp",   32'(temp_out),   32'd0);
    check("midrst_th",     32'(th_out),     32'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_idle",    32'(busy),          32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onewire_scratchpad_rx.md
# onewire_scratchpad_rx

Downstream consumer of the 1-Wire master's read stage. Accepts the byte stream produced by the bus read logic, assembles a DS18B20-style scratchpad frame (default 9 bytes), checks the Dallas/Maxim CRC-8 bit-serially, and publishes the temperature, alarm and configuration fields only for frames that pass CRC. Sits between the 1-Wire master and any register or display logic that uses the sensor value.

## Interface
- FRAME_BYTES, 9, bytes per frame including the trailing CRC byte; legal range 3..15.
- CRC_POLY, 8'h8C, reflected CRC-8 polynomial (x^8+x^5+x^4+1).

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- frame_start  in  1  one-cycle pulse; opens a new frame and aborts any frame in progress.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_in  in  8  received byte, LSB = first bit on the wire.
- byte_ready  out  1  block can accept a byte this cycle.
- busy  out  1  frame open (any state other than IDLE).
- frame_done  out  1  one-cycle pulse when a frame's CRC check completes.
- crc_ok  out  1  result of the last completed frame; 1 = residue zero.
- temp_out  out  16  {byte1, byte0} of the last CRC-good frame.
- th_out  out  8  byte2 of the last CRC-good frame.
- tl_out  out  8  byte3 of the last CRC-good frame.
- config_out  out  8  byte4 of the last CRC-good frame.

## Operation
- States: IDLE, WAIT_BYTE, SHIFT, DONE.
- IDLE: byte_ready=0, busy=0. frame_start -> WAIT_BYTE with crc=0 and byte_cnt=0.
- WAIT_BYTE: byte_ready=1. byte_valid&byte_ready -> capture byte_in into the shift register, store it at byte index byte_cnt if the index is <5, and go to SHIFT with bit_cnt=0.
- SHIFT: one bit per cycle, LSB first. fb = crc[0]^bit; crc = {1'b0, crc[7:1]} ^ (fb ? CRC_POLY : 0). After bit 7, byte_cnt increments. If byte_cnt has reached FRAME_BYTES, go to DONE; otherwise return to WAIT_BYTE. byte_ready=0 throughout SHIFT.
- DONE: one cycle. frame_done=1. crc_ok is set to (crc==0).
  - If crc==0, temp_out, th_out, tl_out and config_out load from the captured bytes 0..4.
  - If crc!=0, those outputs hold their previous values.
  - Next state is IDLE.
- frame_start has priority in every state: the frame restarts, crc/byte_cnt/bit_cnt clear, the next state is WAIT_BYTE, a coincident byte_valid is dropped, and no frame_done is generated for the aborted frame.
- byte_valid while byte_ready=0 is ignored. No byte is queued.
- crc_ok and the data outputs change only in the DONE cycle.
- An all-zero frame passes CRC (crc_ok=1). This is intentional Dallas behaviour. Presence-check filtering belongs upstream.
- Byte counter width: 4 bits. Bit counter width: 3 bits.

## Timing
- Reset: state IDLE; byte_ready, busy, frame_done, crc_ok = 0; temp_out, th_out, tl_out, config_out = 0; crc, counters = 0.
- frame_start registered in cycle T gives byte_ready=1 and busy=1 from cycle T+1.
- A byte accepted in cycle A: SHIFT occupies cycles A+1..A+8, and byte_ready is high again at A+9 if this was not the last byte.
- Minimum per-byte spacing is 9 cycles. Actual 1-Wire byte spacing (~60 µs/bit) is far larger, so byte_ready never throttles a real bus.
- Last byte accepted in cycle A: DONE/frame_done is in cycle A+9, and the new crc_ok and data outputs are visible from cycle A+10. IDLE follows at A+10.
- rst asserted mid-frame returns every register to its reset value on the next edge. frame_done is not pulsed.

## Test plan
- Reset: hold rst 2 cycles -> all outputs 0, byte_ready=0, busy=0.
- Good frame: frame_start, then bytes 50 05 4B 46 7F FF 0C 10 1C, each presented when byte_ready=1 -> a single frame_done 9 cycles after the last accept, crc_ok=1, temp_out=16'h0550, th_out=8'h4B, tl_out=8'h46, config_out=8'h7F.
- Bad CRC: same frame with last byte 1D after a good frame -> frame_done, crc_ok=0, temp_out still 16'h0550.
- Abort: frame_start, 4 bytes, frame_start again, then the full good frame from above -> exactly one frame_done, crc_ok=1, no pulse for the aborted frame.
- Backpressure: hold byte_valid=1 with a constant byte across SHIFT cycles -> exactly one accept per 9 cycles, and byte_cnt reaches 9 after 9 accepts, not earlier.
- All-zero frame of 9 bytes 00 -> crc_ok=1, temp_out=16'h0000. Then rst mid-frame after 3 bytes -> busy=0 next cycle and no frame_done.
